// File: rtl/spike_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spike_pkg : geometry constants and scan FSM states shared by spike blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package spike_pkg;

  localparam int NUM_SPIKES = 24;
  localparam int SPIKE_W    = 16;
  localparam int SPIKE_H    = 10;
  localparam int MAN_W      = 16;
  localparam int MAN_H      = 20;
  localparam int PARK_Y     = 360;
  localparam int COORD_W    = 10;
  localparam int IDX_W      = 5;
  localparam int STRIP_H    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/spike_box_overlap.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spike_box_overlap : inclusive overlap of player box and one spike's lethal strip
// Rev 1.0
// ----------------------------------------------------------------------------
module spike_box_overlap
  import spike_pkg::*;
(
  input  logic [COORD_W-1:0] i_man_x,
  input  logic [COORD_W-1:0] i_man_y,
  input  logic [COORD_W-1:0] i_spike_x,
  input  logic [COORD_W-1:0] i_spike_y,
  input  logic               i_dir,
  output logic               o_hit
);

  logic [COORD_W:0] w_man_x0, w_man_x1, w_man_y0, w_man_y1;
  logic [COORD_W:0] w_sp_x0, w_sp_x1, w_sp_y0, w_sp_y1;
  logic             w_parked;

  // One extra bit keeps box edges near the screen limit from wrapping.
  always_comb begin
    w_man_x0 = {1'b0, i_man_x};
    w_man_x1 = w_man_x0 + (COORD_W+1)'(MAN_W - 1);
    w_man_y0 = {1'b0, i_man_y};
    w_man_y1 = w_man_y0 + (COORD_W+1)'(MAN_H - 1);
    w_sp_x0  = {1'b0, i_spike_x};
    w_sp_x1  = w_sp_x0 + (COORD_W+1)'(SPIKE_W - 1);
    w_sp_y0  = {1'b0, i_spike_y} + (i_dir ? (COORD_W+1)'(SPIKE_H - STRIP_H) : '0);
    w_sp_y1  = w_sp_y0 + (COORD_W+1)'(STRIP_H - 1);
    w_parked = (i_spike_y >= COORD_W'(PARK_Y));
    o_hit    = !w_parked
               && (w_sp_x0 <= w_man_x1) && (w_man_x0 <= w_sp_x1)
               && (w_sp_y0 <= w_man_y1) && (w_man_y0 <= w_sp_y1);
  end

endmodule
`default_nettype wire

// File: rtl/spike_hazard_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spike_hazard_checker : per-frame scan of all spikes against the player box
// Rev 1.0
// ----------------------------------------------------------------------------
module spike_hazard_checker
  import spike_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] ManX,
  input  logic [COORD_W-1:0] ManY,
  input  logic [COORD_W-1:0] SpikeX [0:NUM_SPIKES-1],
  input  logic [COORD_W-1:0] SpikeY [0:NUM_SPIKES-1],
  input  logic               Draw_direction [0:NUM_SPIKES-1],
  input  logic               Revive,
  output logic               Dead,
  output logic [IDX_W-1:0]   Hit_index,
  output logic               Scan_busy,
  output logic               Scan_done,
  output logic               Overrun
);

  scan_state_t        r_state, w_state_next;
  logic               r_fsync_meta, r_fsync, r_fsync_d;
  logic               w_start;
  logic [IDX_W-1:0]   r_idx;
  logic [COORD_W-1:0] r_man_x, r_man_y;
  logic               r_hit_found;
  logic [IDX_W-1:0]   r_hit_idx;
  logic               w_hit;
  logic               w_last;

  assign w_start = r_fsync & ~r_fsync_d;
  assign w_last  = (r_idx == IDX_W'(NUM_SPIKES - 1));

  spike_box_overlap u_overlap (
    .i_man_x   (r_man_x),
    .i_man_y   (r_man_y),
    .i_spike_x (SpikeX[r_idx]),
    .i_spike_y (SpikeY[r_idx]),
    .i_dir     (Draw_direction[r_idx]),
    .o_hit     (w_hit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    Scan_busy    = 1'b0;
    Scan_done    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_SNAP;
      ST_SNAP: begin
        Scan_busy    = 1'b1;
        w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        Scan_busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        Scan_done    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fsync_meta <= 1'b0;
      r_fsync      <= 1'b0;
      r_fsync_d    <= 1'b0;
      r_idx        <= '0;
      r_man_x      <= '0;
      r_man_y      <= '0;
      r_hit_found  <= 1'b0;
      r_hit_idx    <= '0;
      Dead         <= 1'b0;
      Hit_index    <= '0;
      Overrun      <= 1'b0;
    end else begin
      r_fsync_meta <= frame_clk;
      r_fsync      <= r_fsync_meta;
      r_fsync_d    <= r_fsync;

      case (r_state)
        ST_SNAP: begin
          r_man_x     <= ManX;
          r_man_y     <= ManY;
          r_idx       <= '0;
          r_hit_found <= 1'b0;
        end
        ST_SCAN: begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_hit && !r_hit_found) begin
            r_hit_found <= 1'b1;
            r_hit_idx   <= r_idx;
          end
        end
        default: ;
      endcase

      // A kill landing this cycle overrides a simultaneous Revive.
      if (r_state == ST_DONE && r_hit_found) begin
        if (!Dead) Hit_index <= r_hit_idx;
        Dead <= 1'b1;
      end else if (Revive) begin
        Dead <= 1'b0;
      end

      if (w_start && r_state != ST_IDLE) Overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_hazard_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spike_hazard_checker : directed self-checking bench for spike_hazard_checker
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spike_hazard_checker;
  import spike_pkg::*;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               frame_clk;
  logic [COORD_W-1:0] ManX, ManY;
  logic [COORD_W-1:0] SpikeX [0:NUM_SPIKES-1];
  logic [COORD_W-1:0] SpikeY [0:NUM_SPIKES-1];
  logic               Draw_direction [0:NUM_SPIKES-1];
  logic               Revive;
  logic               Dead;
  logic [IDX_W-1:0]   Hit_index;
  logic               Scan_busy, Scan_done, Overrun;

  int checks   = 0;
  int failures = 0;
  int lat;
  int done_cnt;
  int done_at;
  logic busy_at_start, busy_in_snap, done_after, busy_after;

  always #10 Clk = ~Clk;

  spike_hazard_checker dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .ManX           (ManX),
    .ManY           (ManY),
    .SpikeX         (SpikeX),
    .SpikeY         (SpikeY),
    .Draw_direction (Draw_direction),
    .Revive         (Revive),
    .Dead           (Dead),
    .Hit_index      (Hit_index),
    .Scan_busy      (Scan_busy),
    .Scan_done      (Scan_done),
    .Overrun        (Overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic park_all();
    for (int i = 0; i < NUM_SPIKES; i++) begin
      SpikeX[i]         = 10'd0;
      SpikeY[i]         = 10'd400;
      Draw_direction[i] = 1'b0;
    end
  endtask

  task automatic set_spike(input int i, input int x, input int y, input logic d);
    SpikeX[i]         = COORD_W'(x);
    SpikeY[i]         = COORD_W'(y);
    Draw_direction[i] = d;
  endtask

  task automatic revive_pulse();
    @(negedge Clk); Revive = 1'b1;
    @(negedge Clk); Revive = 1'b0;
    #1;
  endtask

  // Latency counts Clk edges after the edge where the synchronized tick rises.
  task automatic run_frame(output int latency);
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    busy_at_start = Scan_busy;
    latency = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (n == 1) busy_in_snap = Scan_busy;
      if (Scan_done) begin
        latency = n;
        break;
      end
    end
    @(posedge Clk); #1;
    done_after = Scan_done;
    busy_after = Scan_busy;
    @(negedge Clk); frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    Revive    = 1'b0;
    ManX      = 10'd200;
    ManY      = 10'd200;
    park_all();
    repeat (3) @(negedge Clk);
    chk("rst_dead",    32'(Dead),      32'd0);
    chk("rst_hit_idx", 32'(Hit_index), 32'd0);
    chk("rst_busy",    32'(Scan_busy), 32'd0);
    chk("rst_done",    32'(Scan_done), 32'd0);
    chk("rst_overrun", 32'(Overrun),   32'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Spike 0 directly under the player's feet.
    set_spike(0, 200, 210, 1'b0);
    run_frame(lat);
    chk("t1_latency",    32'(lat),           32'd26);
    chk("t1_busy_start", 32'(busy_at_start), 32'd0);
    chk("t1_busy_snap",  32'(busy_in_snap),  32'd1);
    chk("t1_done_pulse", 32'(done_after),    32'd0);
    chk("t1_busy_after", 32'(busy_after),    32'd0);
    chk("t1_dead",       32'(Dead),          32'd1);
    chk("t1_hit_idx",    32'(Hit_index),     32'd0);

    revive_pulse();
    chk("rev1_dead",    32'(Dead),      32'd0);
    chk("rev1_hit_idx", 32'(Hit_index), 32'd0);

    // X edge: 216 is one pixel past the box, 215 touches it.
    park_all();
    set_spike(5, 216, 210, 1'b0);
    run_frame(lat);
    chk("t2a_dead", 32'(Dead), 32'd0);
    set_spike(5, 215, 210, 1'b0);
    run_frame(lat);
    chk("t2b_dead",    32'(Dead),      32'd1);
    chk("t2b_hit_idx", 32'(Hit_index), 32'd5);
    revive_pulse();

    // Two overlapping spikes (3 down, 9 up): the lower index wins.
    park_all();
    ManX = 10'd100;
    ManY = 10'd100;
    set_spike(3, 90, 95, 1'b1);
    set_spike(9, 110, 100, 1'b0);
    run_frame(lat);
    chk("t3_dead",    32'(Dead),      32'd1);
    chk("t3_hit_idx", 32'(Hit_index), 32'd3);

    // Already dead: a new hit by spike 9 alone must not reload the index.
    set_spike(3, 0, 400, 1'b0);
    run_frame(lat);
    chk("t3b_dead",    32'(Dead),      32'd1);
    chk("t3b_hit_idx", 32'(Hit_index), 32'd3);
    revive_pulse();
    chk("rev3_dead", 32'(Dead), 32'd0);

    // Parked spike over the player is ignored.
    park_all();
    set_spike(7, 100, 360, 1'b0);
    ManY = 10'd350;
    run_frame(lat);
    chk("t4_dead",    32'(Dead),    32'd0);
    chk("t4_latency", 32'(lat),     32'd26);
    chk("t4_overrun", 32'(Overrun), 32'd0);

    // Second frame edge lands mid-scan.
    park_all();
    ManY = 10'd100;
    set_spike(2, 100, 100, 1'b0);
    done_cnt = 0;
    done_at  = -1;
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk); #1;
      if (Scan_done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 4)  frame_clk = 1'b0;
      if (c == 11) frame_clk = 1'b1;
      if (c == 16) frame_clk = 1'b0;
    end
    chk("t5_overrun",  32'(Overrun),   32'd1);
    chk("t5_done_cnt", 32'(done_cnt),  32'd1);
    chk("t5_done_at",  32'(done_at),   32'd26);
    chk("t5_dead",     32'(Dead),      32'd1);
    chk("t5_hit_idx",  32'(Hit_index), 32'd2);
    revive_pulse();
    chk("t5_rev_dead",    32'(Dead),    32'd0);
    chk("t5_rev_overrun", 32'(Overrun), 32'd1);

    // Reset asserted in scan cycle 12.
    park_all();
    set_spike(4, 100, 100, 1'b0);
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    repeat (14) @(posedge Clk);
    #1;
    chk("t6_busy_pre", 32'(Scan_busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_dead",    32'(Dead),      32'd0);
    chk("t6_rst_hit_idx", 32'(Hit_index), 32'd0);
    chk("t6_rst_busy",    32'(Scan_busy), 32'd0);
    chk("t6_rst_done",    32'(Scan_done), 32'd0);
    chk("t6_rst_overrun", 32'(Overrun),   32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk); #1;
      if (Scan_done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt),  32'd0);
    chk("t6_idle",    32'(Scan_busy), 32'd0);
    run_frame(lat);
    chk("t6_latency", 32'(lat),       32'd26);
    chk("t6_dead",    32'(Dead),      32'd1);
    chk("t6_hit_idx", 32'(Hit_index), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_hazard_checker.md
SPIKE_HAZARD_CHECKER -- requirements
Module: spike_hazard_checker

Interface
REQ-001 SHALL have port Clk, input, 1 bit: 50 MHz system clock; the only clock.
REQ-002 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port frame_clk, input, 1 bit: frame tick, treated as data and synchronized into Clk.
REQ-004 SHALL have ports ManX and ManY, inputs, 10 bits each: top-left of player box.
REQ-005 SHALL have ports SpikeX[0:NUM_SPIKES-1] and SpikeY[0:NUM_SPIKES-1], inputs, 10 bits each: spike top-left from the spike updater.
REQ-006 SHALL have port Draw_direction[0:NUM_SPIKES-1], input, 1 bit each: 0 = up, 1 = down.
REQ-007 SHALL have port Revive, input, 1 bit: synchronous request to clear Dead.
REQ-008 SHALL have port Dead, output, 1 bit: sticky player-killed flag.
REQ-009 SHALL have port Hit_index, output, 5 bits: lowest spike index that caused the latest kill.
REQ-010 SHALL have port Scan_busy, output, 1 bit: high while a scan is in progress.
REQ-011 SHALL have port Scan_done, output, 1 bit: one-Clk pulse at the end of each scan.
REQ-012 SHALL have port Overrun, output, 1 bit: sticky flag, frame tick arrived while busy.

Function
REQ-013 SHALL synchronize frame_clk with 2 flops; its rising edge (sync output 0->1) is the start event.
REQ-014 SHALL implement FSM IDLE -> SNAP -> SCAN -> DONE -> IDLE.
- IDLE: leaves on a start event.
- SNAP: 1 cycle; latches ManX/ManY.
- SCAN: 24 cycles; index i = 0..23, one spike per cycle.
- DONE: 1 cycle.
REQ-015 SHALL sample spike arrays live during SCAN; the producer guarantees they are stable from 2 Clk cycles after frame_clk rises until the next rise.
REQ-016 SHALL use player box X [ManX, ManX+MAN_W-1] and Y [ManY, ManY+MAN_H-1].
REQ-017 SHALL use lethal strip X [SpikeX, SpikeX+SPIKE_W-1] for every spike.
- Up spikes (direction 0): Y [SpikeY, SpikeY+3].
- Down spikes (direction 1): Y [SpikeY+SPIKE_H-4, SpikeY+SPIKE_H-1].
REQ-018 SHALL count a hit on inclusive overlap on both axes, using 11-bit unsigned arithmetic (no 10-bit wrap).
REQ-019 SHALL skip (never hit) a spike whose SpikeY >= PARK_Y (360).
REQ-020 SHALL record the first hit index in scan order; later hits in the same scan do not change it.
REQ-021 SHALL, in DONE when a hit occurred, set Dead=1, load Hit_index, and pulse Scan_done; when no hit occurred, Dead and Hit_index hold.
REQ-022 SHALL clear Dead on Revive=1 in any state except DONE-with-hit, where the hit wins; Hit_index holds.
REQ-023 SHALL leave Dead unchanged by new hits while already Dead; Hit_index likewise holds.
REQ-024 SHALL, on a start event in SNAP/SCAN/DONE, set Overrun=1 and not restart or queue the scan; Overrun clears only on reset.
REQ-025 SHALL drive Scan_busy=1 in SNAP and SCAN; start-event-to-Scan_done latency is exactly 26 Clk cycles.

Reset
REQ-026 SHALL, on Reset_n low, asynchronously force state IDLE, index 0, and synchronizer flops 0, with outputs Dead=0, Hit_index=0, Scan_busy=0, Scan_done=0, Overrun=0.
REQ-027 SHALL abandon a scan on reset mid-scan with no Scan_done; after release, the first start event requires a fresh 0->1 of the synchronized frame_clk.

Structure
REQ-028 SHALL take NUM_SPIKES=24, SPIKE_W=16, SPIKE_H=10, MAN_W=16, MAN_H=20, PARK_Y=360 and the FSM state enum from shared package spike_pkg; the spike updater uses the same package.
REQ-029 SHALL place the box test in combinational sub-module spike_box_overlap, with inputs man box, spike x/y, and direction, and output hit.

Verification
REQ-030 SHALL cover: Man (200,200), spike0 (200,210) up, others parked, frame edge -> Dead=1, Hit_index=0, Scan_done exactly 26 Clk cycles after the sync edge.
REQ-031 SHALL cover: Man (200,200), spike5 (216,210) up -> no hit (x just outside); same at (215,210) -> Dead=1, Hit_index=5.
REQ-032 SHALL cover: Man at (100,100), spikes 3 and 9 both overlapping -> Hit_index=3.
REQ-033 SHALL cover: a spike with SpikeY=360 positioned over the player -> Dead stays 0.
REQ-034 SHALL cover: a second frame_clk edge 10 cycles into SCAN -> Overrun=1, exactly one Scan_done; Revive pulsed in IDLE -> Dead=0.
REQ-035 SHALL cover: Reset_n low during SCAN cycle 12 -> all outputs 0 immediately, no Scan_done until the next frame edge.
